// File: rtl/serial_pattern_tx.sv
// MSB-first serializer with per-bit valid/nibble/full strobes. The bit source is
// either a word taken over a valid/ready handshake or a fixed pattern repeated while requested.
module serial_pattern_tx #(
    parameter int WIDTH = 32,
    parameter int FDW = 0,
    parameter logic [((FDW > 0) ? FDW : 1)-1:0] FIXED_DATA = '0,
    parameter int DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic             pattern_en_i,
    output logic             data_o,
    output logic             data_val_o,
    output logic             nibble_o,
    output logic             full_o,
    output logic             busy_o
);

    localparam int MAXW = (WIDTH > FDW) ? WIDTH : FDW;
    localparam int BW = $clog2(MAXW);
    localparam int DW = $clog2(DIV) + 1;
    localparam int PW = (FDW > 0) ? FDW : 1;
    localparam logic [BW-1:0] WLAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PLAST = BW'(PW - 1);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
    localparam logic PAT_OK = (FDW > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PATTERN = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [BW-1:0]    bit_r, bit_s;
    logic [DW-1:0]    div_r, div_s;
    logic [WIDTH-1:0] word_r, word_s;
    logic             data_r, data_s;
    logic             val_r, val_s;
    logic             nib_r, nib_s;
    logic             full_r, full_s;
    logic             busy_r, busy_s;
    logic             ready_s;
    logic             pat_req_s, div_end_s;
    logic             load_s, start_pat_s, advance_s, go_idle_s;

    // Pattern bit for index idx, counted from the MSB of FIXED_DATA
    function automatic logic pat_bit(input logic [BW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < PW; k++) begin
            if (idx == BW'(PW - 1 - k)) begin
                r = FIXED_DATA[k];
            end
        end
        return r;
    endfunction

    // Next-state decision, then the action it implies on counters and outputs
    always_comb begin
        state_s     = state_r;
        bit_s       = bit_r;
        div_s       = div_r;
        word_s      = word_r;
        data_s      = data_r;
        val_s       = 1'b0;
        nib_s       = 1'b0;
        full_s      = 1'b0;
        ready_s     = 1'b0;
        load_s      = 1'b0;
        start_pat_s = 1'b0;
        advance_s   = 1'b0;
        go_idle_s   = 1'b0;
        pat_req_s   = pattern_en_i & PAT_OK;
        div_end_s   = (div_r == DLAST);

        case (state_r)
            IDLE: begin
                if (pat_req_s) begin
                    start_pat_s = 1'b1;
                end else begin
                    ready_s = 1'b1;
                    if (word_valid_i) begin
                        load_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!div_end_s) begin
                    div_s = div_r + DW'(1);
                end else if (bit_r != WLAST) begin
                    advance_s = 1'b1;
                end else if (pat_req_s) begin
                    start_pat_s = 1'b1;
                end else begin
                    // Last bit period of a word: a follow-on word continues without a gap
                    ready_s = 1'b1;
                    if (word_valid_i) begin
                        load_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
            end
            PATTERN: begin
                if (!div_end_s) begin
                    div_s = div_r + DW'(1);
                end else if (bit_r != PLAST) begin
                    advance_s = 1'b1;
                end else if (pat_req_s) begin
                    start_pat_s = 1'b1;
                end else begin
                    go_idle_s = 1'b1;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        if (load_s) begin
            state_s = SHIFT;
            bit_s   = '0;
            div_s   = '0;
            word_s  = word_i << 1;
            data_s  = word_i[WIDTH-1];
            val_s   = 1'b1;
            nib_s   = 1'b1;
        end else if (start_pat_s) begin
            state_s = PATTERN;
            bit_s   = '0;
            div_s   = '0;
            data_s  = pat_bit('0);
            val_s   = 1'b1;
            nib_s   = 1'b1;
            full_s  = (PLAST == '0);
        end else if (advance_s) begin
            bit_s = bit_r + BW'(1);
            div_s = '0;
            val_s = 1'b1;
            nib_s = (bit_s[1:0] == 2'd0);
            if (state_r == SHIFT) begin
                data_s = word_r[WIDTH-1];
                word_s = word_r << 1;
                full_s = (bit_s == WLAST);
            end else begin
                data_s = pat_bit(bit_s);
                full_s = (bit_s == PLAST);
            end
        end else if (go_idle_s) begin
            state_s = IDLE;
            bit_s   = '0;
            div_s   = '0;
            data_s  = 1'b0;
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != IDLE);
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            bit_r   <= '0;
            div_r   <= '0;
            word_r  <= '0;
            data_r  <= 1'b0;
            val_r   <= 1'b0;
            nib_r   <= 1'b0;
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            bit_r   <= bit_s;
            div_r   <= div_s;
            word_r  <= word_s;
            data_r  <= data_s;
            val_r   <= val_s;
            nib_r   <= nib_s;
            full_r  <= full_s;
            busy_r  <= busy_s;
        end
    end

    assign word_ready_o = ready_s;
    assign data_o       = data_r;
    assign data_val_o   = val_r;
    assign nibble_o     = nib_r;
    assign full_o       = full_r;
    assign busy_o       = busy_r;

endmodule
